knn_topk_voter: RTL and testbench

Streaming K-nearest-neighbour selector and majority voter for the kNN classifier datapath. Sits downstream of the distance engine. It consumes one (distance, type) pair per cycle for each training sample and keeps a sorted list of the K smallest distances. When the sample stream closes, it tallies class votes and emits the inferred type with a one-cycle done pulse. It generalises the fixed-K vote stage with a parametrised K/L, a ready/valid input, a sample cap and optional rank-weighted voting.

---
 rtl/knn_topk_voter.sv | 194 +++++++++++++++++++
 tb/tb_knn_topk_voter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/knn_topk_voter.sv
// knn_topk_voter: streaming top-K nearest-neighbour selector with class majority vote.
// Latency: inference_done pulses n+1 cycles after the closing accept (n = kept entries, 1..K).
// Backpressure: dist_ready high only in COLLECT, one pair per cycle with no bubbles; low elsewhere.
// Build option: define KNN_WEIGHTED_VOTE_EN for rank-weighted voting (rank r adds K-r votes).
module knn_topk_voter #(
    parameter int W      = 32,
    parameter int TYPE_W = 3,
    parameter int K      = 7,
    parameter int L      = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    dist_valid,
    output logic                    dist_ready,
    input  logic [W-1:0]            dist_in,
    input  logic [TYPE_W-1:0]       type_in,
    input  logic                    last,
    output logic [$clog2(L+1)-1:0]  sample_count,
    output logic                    busy,
    output logic [TYPE_W-1:0]       inferred_type,
    output logic                    inference_done
);

    localparam int NUM_TYPES = 2**TYPE_W;
    localparam int SCW       = $clog2(L+1);
    localparam int NW        = $clog2(K+1);
`ifdef KNN_WEIGHTED_VOTE_EN
    localparam int VW        = $clog2(K*(K+1)/2+1);
`else
    localparam int VW        = $clog2(K+1);
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_TALLY   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       dist_q  [K];
    logic [W-1:0]       dist_d  [K];
    logic [TYPE_W-1:0]  type_q  [K];
    logic [TYPE_W-1:0]  type_d  [K];
    logic [VW-1:0]      votes_q [NUM_TYPES];
    logic [VW-1:0]      votes_d [NUM_TYPES];
    logic [NW-1:0]      n_q, n_d;          // valid entries occupy ranks 0..n-1
    logic [NW-1:0]      idx_q, idx_d;      // tally walk pointer
    logic [SCW-1:0]     sc_q, sc_d;
    logic [TYPE_W-1:0]  inf_q, inf_d;
    logic               done_q, done_d;

    logic [NW-1:0]      ins_pos;
    logic               ins_en;
    logic [VW-1:0]      weight;
    logic [TYPE_W-1:0]  best_t;
    logic [VW-1:0]      best_v;

    // Insert position: count of kept entries with distance <= incoming, so ties keep arrival order
    always_comb begin
        ins_pos = '0;
        for (int i = 0; i < K; i++) begin
            if ((NW'(i) < n_q) && (dist_q[i] <= dist_in)) begin
                ins_pos = ins_pos + 1'b1;
            end
        end
        ins_en = (n_q < NW'(K)) || (dist_in < dist_q[K-1]);
    end

    // Vote weight for the entry currently being tallied
    always_comb begin
`ifdef KNN_WEIGHTED_VOTE_EN
        weight = VW'(K) - VW'(idx_q);
`else
        weight = VW'(1);
`endif
    end

    // Argmax over class counters; strict compare keeps the smallest index on ties
    always_comb begin
        best_t = '0;
        best_v = votes_q[0];
        for (int t = 1; t < NUM_TYPES; t++) begin
            if (votes_q[t] > best_v) begin
                best_v = votes_q[t];
                best_t = TYPE_W'(t);
            end
        end
    end

    // Next-state: collection with shift-insert, tally walk, result capture
    always_comb begin
        state_d = state_q;
        dist_d  = dist_q;
        type_d  = type_q;
        votes_d = votes_q;
        n_d     = n_q;
        idx_d   = idx_q;
        sc_d    = sc_q;
        inf_d   = inf_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d   = '0;
                    sc_d  = '0;
                    idx_d = '0;
                    for (int t = 0; t < NUM_TYPES; t++) begin
                        votes_d[t] = '0;
                    end
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (dist_valid) begin
                    sc_d = sc_q + 1'b1;
                    if (ins_en) begin
                        for (int i = 0; i < K; i++) begin
                            if (NW'(i) == ins_pos) begin
                                dist_d[i] = dist_in;
                                type_d[i] = type_in;
                            end
                        end
                        // Entries behind the insert point slide down one rank; rank K-1 falls off
                        for (int i = 1; i < K; i++) begin
                            if (NW'(i) > ins_pos) begin
                                dist_d[i] = dist_q[i-1];
                                type_d[i] = type_q[i-1];
                            end
                        end
                        if (n_q != NW'(K)) begin
                            n_d = n_q + 1'b1;
                        end
                    end
                    if (last || (sc_q == SCW'(L-1))) begin
                        idx_d   = '0;
                        state_d = S_TALLY;
                    end
                end
            end
            S_TALLY: begin
                votes_d[type_q[idx_q]] = votes_q[type_q[idx_q]] + weight;
                idx_d = idx_q + 1'b1;
                if (idx_q == n_q - 1'b1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                inf_d   = best_t;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            sc_q    <= '0;
            inf_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < K; i++) begin
                dist_q[i] <= '0;
                type_q[i] <= '0;
            end
            for (int t = 0; t < NUM_TYPES; t++) begin
                votes_q[t] <= '0;
            end
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            sc_q    <= sc_d;
            inf_q   <= inf_d;
            done_q  <= done_d;
            dist_q  <= dist_d;
            type_q  <= type_d;
            votes_q <= votes_d;
        end
    end

    assign dist_ready     = (state_q == S_COLLECT);
    // The done pulse cycle still counts as busy so busy drops as the pulse ends
    assign busy           = (state_q != S_IDLE) || done_q;
    assign sample_count   = sc_q;
    assign inferred_type  = inf_q;
    assign inference_done = done_q;

endmodule

// File: tb/tb_knn_topk_voter.sv
// tb_knn_topk_voter: directed bench for knn_topk_voter with K=7, L=64.
// Latency: outputs sampled 1ns after each rising edge; inputs driven there too.
// Backpressure: relies on dist_ready staying high through COLLECT; every wait is cycle-bounded.
module tb_knn_topk_voter;

    localparam int W      = 32;
    localparam int TYPE_W = 3;
    localparam int K      = 7;
    localparam int L      = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   dist_valid;
    logic                   dist_ready;
    logic [W-1:0]           dist_in;
    logic [TYPE_W-1:0]      type_in;
    logic                   last;
    logic [$clog2(L+1)-1:0] sample_count;
    logic                   busy;
    logic [TYPE_W-1:0]      inferred_type;
    logic                   inference_done;

    int checks = 0;
    int errors = 0;
    int cyc;

    knn_topk_voter #(.W(W), .TYPE_W(TYPE_W), .K(K), .L(L)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .dist_valid     (dist_valid),
        .dist_ready     (dist_ready),
        .dist_in        (dist_in),
        .type_in        (type_in),
        .last           (last),
        .sample_count   (sample_count),
        .busy           (busy),
        .inferred_type  (inferred_type),
        .inference_done (inference_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [TYPE_W-1:0] t, input logic l);
        dist_valid = 1'b1;
        dist_in    = d;
        type_in    = t;
        last       = l;
        tick();
        dist_valid = 1'b0;
        last       = 1'b0;
    endtask

    // Cycles from the closing accept until inference_done is seen; 200 means it never came
    task automatic wait_done(output int n);
        n = 0;
        while (!inference_done && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        dist_valid = 1'b0;
        dist_in    = '0;
        type_in    = '0;
        last       = 1'b0;
        #12;
        check("rst_ready", dist_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_count", sample_count, 0);
        check("rst_type", inferred_type, 0);
        check("rst_done", inference_done, 0);
        tick();
        rst = 1'b1;
        tick();

        // Basic: ten ascending distances, types 2 then 5; ranks 0..6 keep four type-2 entries
        do_start();
        check("basic_ready", dist_ready, 1);
        check("basic_busy", busy, 1);
        for (int i = 0; i < 10; i++) begin
            send(W'(10*i), (i < 4) ? 3'd2 : 3'd5, i == 9);
        end
        check("basic_ready_drop", dist_ready, 0);
        check("basic_count", sample_count, 10);
        wait_done(cyc);
        check("basic_done_lat", cyc, 8);
        check("basic_type", inferred_type, 2);
        tick();
        check("basic_done_fall", inference_done, 0);
        check("basic_busy_fall", busy, 0);

        // dist_valid in IDLE is ignored
        dist_valid = 1'b1;
        tick();
        dist_valid = 1'b0;
        check("idle_valid_ignored", sample_count, 10);

        // Reset mid-COLLECT after five accepts
        do_start();
        for (int i = 0; i < 5; i++) begin
            send(W'(i + 1), 3'd6, 1'b0);
        end
        rst = 1'b0;
        #2;
        check("midrst_ready", dist_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_count", sample_count, 0);
        check("midrst_type", inferred_type, 0);
        check("midrst_done", inference_done, 0);
        tick();
        rst = 1'b1;
        tick();
        do_start();
        send(W'(3), 3'd4, 1'b1);
        wait_done(cyc);
        check("single_done_lat", cyc, 2);
        check("single_type", inferred_type, 4);
        tick();

        // Distance tie: 8th sample at equal distance must not displace rank 6
        do_start();
        for (int i = 0; i < 8; i++) begin
            send(W'(50), TYPE_W'(i), i == 7);
        end
        wait_done(cyc);
        check("tie_done_lat", cyc, 8);
        check("tie_type", inferred_type, 0);
        tick();

        // Fewer than K entries and a vote tie broken by smaller index
        do_start();
        send(W'(9), 3'd6, 1'b0);
        send(W'(4), 3'd3, 1'b1);
        wait_done(cyc);
        check("few_done_lat", cyc, 3);
        check("few_type", inferred_type, 3);
        tick();

        // L cap: 61 type-1 samples at 200 down to 140, then type 7 at 2,1,0; last never set
        do_start();
        for (int i = 0; i < 61; i++) begin
            send(W'(200 - i), 3'd1, 1'b0);
        end
        send(W'(2), 3'd7, 1'b0);
        send(W'(1), 3'd7, 1'b0);
        check("cap_ready_before", dist_ready, 1);
        check("cap_count_before", sample_count, 63);
        send(W'(0), 3'd7, 1'b0);
        check("cap_ready_after", dist_ready, 0);
        check("cap_count", sample_count, 64);
        wait_done(cyc);
        check("cap_done_lat", cyc, 8);
`ifdef KNN_WEIGHTED_VOTE_EN
        check("cap_type", inferred_type, 7);
`else
        check("cap_type", inferred_type, 1);
`endif
        tick();

        // Weighting: three near type-1 entries against four farther type-4 entries
        do_start();
        for (int i = 1; i <= 7; i++) begin
            send(W'(i), (i <= 3) ? 3'd1 : 3'd4, i == 7);
        end
        wait_done(cyc);
        check("wt_done_lat", cyc, 8);
`ifdef KNN_WEIGHTED_VOTE_EN
        check("wt_type", inferred_type, 1);
`else
        check("wt_type", inferred_type, 4);
`endif
        tick();
        check("wt_done_fall", inference_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
